// File: rtl/kgp_trace_buffer.sv
// kgp_trace_buffer
//
// Capture/trace unit for the KGP_RISC `rout` output bus. It records observed
// output-register values into a FIFO, optionally tagged with a free-running
// cycle timestamp. A bench or debug host drains the FIFO through a show-ahead
// valid/ready port.
//
// Optional feature macro: TRACE_TS_EN
//   defined   : timestamp counter present; each entry stores TS_W timestamp
//               bits, which appear on rd_ts.
//   undefined : no counter and no timestamp storage; rd_ts is tied to 0.
//
// Parameters
//   DATA_W : width of the captured value (matches CPU rout)
//   DEPTH  : FIFO entries, power of two, >= 2
//   TS_W   : timestamp counter width
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   rout_in    in   value observed from CPU rout
//   cap_en     in   capture enable
//   cap_mode   in   0 = capture on change, 1 = capture every enabled cycle
//   wrap_mode  in   0 = drop new sample when full, 1 = overwrite oldest
//   rd_valid   out  FIFO head valid
//   rd_ready   in   consumer accepts head
//   rd_data    out  head value (0 while empty)
//   rd_ts      out  head timestamp (0 while empty or feature disabled)
//   count      out  current occupancy
//   overflow   out  sticky: at least one entry lost or overwritten
//   clr_ovf    in   synchronous clear of overflow
module kgp_trace_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          rout_in,
  input  logic                       cap_en,
  input  logic                       cap_mode,
  input  logic                       wrap_mode,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [DATA_W-1:0]          rd_data,
  output logic [TS_W-1:0]            rd_ts,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  input  logic                       clr_ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Control state (asynchronously reset)
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              prev_valid_q, prev_valid_d;

  // Data state (never reset; prev_value is only meaningful when prev_valid)
  logic [DATA_W-1:0] prev_value_q, prev_value_d;
  logic [DATA_W-1:0] mem_data_q [DEPTH];

  // Per-cycle decisions
  logic capture;
  logic empty;
  logic full;
  logic pop;
  logic wr_en;
  logic lose_head;
  logic ovf_set;

  always_comb begin
    capture   = cap_en && (cap_mode || !prev_valid_q || (rout_in != prev_value_q));
    empty     = (count_q == '0);
    full      = (count_q == FULL_CNT);
    pop       = !empty && rd_ready;
    wr_en     = 1'b0;
    lose_head = 1'b0;
    ovf_set   = 1'b0;

    if (capture) begin
      if (!full || pop) begin
        // A pop in the same cycle frees a slot, so a full FIFO loses nothing.
        wr_en = 1'b1;
      end else begin
        ovf_set = 1'b1;
        if (wrap_mode) begin
          // Overwrite: the tail slot is the current head, so both advance.
          wr_en     = 1'b1;
          lose_head = 1'b1;
        end
      end
    end

    wr_ptr_d = wr_en ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = (pop || lose_head) ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;

    // An overwrite both adds and removes an entry, so it leaves count alone.
    count_d = count_q;
    case ({wr_en && !lose_head, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Setting wins over a simultaneous clear.
    if (ovf_set) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end

    prev_value_d = cap_en ? rout_in : prev_value_q;
    prev_valid_d = cap_en ? 1'b1    : prev_valid_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      prev_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      prev_valid_q <= prev_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    prev_value_q <= prev_value_d;
    if (wr_en) begin
      mem_data_q[wr_ptr_q] <= rout_in;
    end
  end

  assign rd_valid = !empty;
  assign rd_data  = empty ? '0 : mem_data_q[rd_ptr_q];
  assign count    = count_q;
  assign overflow = overflow_q;

`ifdef TRACE_TS_EN
  logic [TS_W-1:0] ts_q, ts_d;
  logic [TS_W-1:0] mem_ts_q [DEPTH];

  // Free-running; wraps modulo 2^TS_W without a flag.
  always_comb begin
    ts_d = ts_q + TS_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_ts_q[wr_ptr_q] <= ts_q;
    end
  end

  assign rd_ts = empty ? '0 : mem_ts_q[rd_ptr_q];
`else
  assign rd_ts = '0;
`endif

endmodule

// File: tb/tb_kgp_trace_buffer.sv
module tb_kgp_trace_buffer;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int TS_W   = 16;

  logic                   clk;
  logic                   reset;
  logic [DATA_W-1:0]      rout_in;
  logic                   cap_en;
  logic                   cap_mode;
  logic                   wrap_mode;
  logic                   rd_valid;
  logic                   rd_ready;
  logic [DATA_W-1:0]      rd_data;
  logic [TS_W-1:0]        rd_ts;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;
  logic                   clr_ovf;

  kgp_trace_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .rout_in   (rout_in),
    .cap_en    (cap_en),
    .cap_mode  (cap_mode),
    .wrap_mode (wrap_mode),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_ts     (rd_ts),
    .count     (count),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [TS_W-1:0]   t;
  } entry_t;

  // Scoreboard / reference state
  entry_t            sb_q[$];
  logic [DATA_W-1:0] m_prev_val;
  logic              m_prev_vld;
  logic              m_ovf;
  logic [TS_W-1:0]   m_ts;

  int n_checks;
  int n_pass;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_prev_vld = 1'b0;
    m_prev_val = '0;
    m_ovf      = 1'b0;
    m_ts       = '0;
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, update the
  // reference on the edge. Called at posedge+1.
  task automatic cyc(input logic en, input logic mode, input logic wrap,
                     input logic [DATA_W-1:0] val, input logic rdy, input logic clr);
    logic   cap, pop, full;
    entry_t e;
    cap_en    = en;
    cap_mode  = mode;
    wrap_mode = wrap;
    rout_in   = val;
    rd_ready  = rdy;
    clr_ovf   = clr;
    #3;
    chk("rd_valid", 64'(rd_valid), 64'(sb_q.size() != 0));
    chk("count", 64'(count), 64'(sb_q.size()));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    if (sb_q.size() == 0) begin
      chk("rd_data_empty", 64'(rd_data), 64'd0);
      chk("rd_ts_empty", 64'(rd_ts), 64'd0);
    end

    cap  = en && (mode || !m_prev_vld || (val != m_prev_val));
    pop  = (sb_q.size() != 0) && rdy;
    full = (sb_q.size() == DEPTH);
    if (en) begin
      m_prev_val = val;
      m_prev_vld = 1'b1;
    end
    if (pop) begin
      e = sb_q.pop_front();
      chk("rd_data", 64'(rd_data), 64'(e.d));
      chk("rd_ts", 64'(rd_ts), 64'(e.t));
    end
    if (cap) begin
      e.d = val;
`ifdef TRACE_TS_EN
      e.t = m_ts;
`else
      e.t = '0;
`endif
      if (!full || pop) begin
        sb_q.push_back(e);
      end else begin
        m_ovf = 1'b1;
        if (wrap) begin
          void'(sb_q.pop_front());
          sb_q.push_back(e);
        end
      end
    end
    if (!(cap && full && !pop) && clr) m_ovf = 1'b0;
    m_ts = m_ts + 16'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 4; i++) begin
      if (sb_q.size() == 0) break;
      cyc(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    end
    chk("drained", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    reset     = 1'b0;
    cap_en    = 1'b0;
    cap_mode  = 1'b0;
    wrap_mode = 1'b0;
    rout_in   = '0;
    rd_ready  = 1'b0;
    clr_ovf   = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rd_valid", 64'(rd_valid), 64'd0);
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_overflow", 64'(overflow), 64'd0);
    reset = 1'b1;

    // Change capture: 0x5 x4 then 0x9 x2 -> two entries
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 32'h5, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, 1'b0, 32'h9, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("change_count", 64'(count), 64'd2);
    drain();

    // Every-cycle capture: 0xA x5
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 32'hA, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("every_count", 64'(count), 64'd5);
    drain();

    // Drop policy: 1..20 into a 16-deep FIFO
    for (int i = 1; i <= 20; i++) cyc(1'b1, 1'b0, 1'b0, 32'(i), 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("drop_count", 64'(count), 64'd16);
    chk("drop_ovf", 64'(overflow), 64'd1);
    chk("drop_head", 64'(rd_data), 64'd1);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("clr_ovf", 64'(overflow), 64'd0);
    drain();

    // Overwrite policy: same stimulus, head becomes 5
    for (int i = 1; i <= 20; i++) cyc(1'b1, 1'b0, 1'b1, 32'(i), 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("wrap_count", 64'(count), 64'd16);
    chk("wrap_ovf", 64'(overflow), 64'd1);
    chk("wrap_head", 64'(rd_data), 64'd5);
    drain();
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

    // Full with concurrent pop
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b1, 1'b0, 32'h100 + 32'(i), 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 32'h77, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("fullpop_count", 64'(count), 64'd16);
    chk("fullpop_ovf", 64'(overflow), 64'd0);
    for (int i = 0; i < DEPTH - 1; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("fullpop_last", 64'(rd_data), 64'h77);
    drain();

    // Empty FIFO with capture and rd_ready together
    cyc(1'b1, 1'b1, 1'b0, 32'h42, 1'b1, 1'b0);
    chk("empty_cap_rdy", 64'(count), 64'd1);
    drain();

    // Reset mid-stream
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0, 32'h30 + 32'(i), 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    chk("midrst_rd_valid", 64'(rd_valid), 64'd0);
    chk("midrst_count", 64'(count), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 32'h35, 1'b0, 1'b0);
    chk("midrst_recapture", 64'(count), 64'd1);
    drain();

    // Mixed random traffic
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 32'($urandom_range(0, 3)),
          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
